// File: rtl/host_io_monitor.sv
`timescale 1ns/1ps
// host_io_monitor
//   Watches one RAM write port per hart. Byte writes to a hart's stdout address
//   become hart-tagged characters in a shared FIFO. The first write to a hart's
//   tohost address is kept as that hart's exit code. The block also reports
//   global done, pass and timeout.
//
//   Handshake: char_data_o/char_hart_o are meaningful while char_valid_o=1 and
//   hold steady until the cycle with char_valid_o && char_ready_i, which pops
//   the entry at that clock edge.
//
// Ports
//   clk_i, arst_ni                      clock, asynchronous active-low reset
//   tohost_addr_i, stdout_addr_i        per-hart byte addresses (quasi-static)
//   mem_we_i/waddr_i/wdata_i/wstrb_i    per-hart snooped write port
//   char_valid_o/ready_i/data_o/hart_o  character stream
//   exited_o, exit_code_o               per-hart exit state (exited_o is the FSM state)
//   all_done_o, all_pass_o, timeout_o   global status
//   drop_cnt_o                          saturating dropped-character count
module host_io_monitor #(
    parameter int NUM_HARTS      = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                            clk_i,
    input  logic                            arst_ni,
    input  logic [NUM_HARTS*ADDR_WIDTH-1:0] tohost_addr_i,
    input  logic [NUM_HARTS*ADDR_WIDTH-1:0] stdout_addr_i,
    input  logic [NUM_HARTS-1:0]            mem_we_i,
    input  logic [NUM_HARTS*ADDR_WIDTH-1:0] mem_waddr_i,
    input  logic [NUM_HARTS*DATA_WIDTH-1:0] mem_wdata_i,
    input  logic [NUM_HARTS*DATA_WIDTH/8-1:0] mem_wstrb_i,
    output logic                            char_valid_o,
    input  logic                            char_ready_i,
    output logic [7:0]                      char_data_o,
    output logic [HW-1:0]                   char_hart_o,
    output logic [NUM_HARTS-1:0]            exited_o,
    output logic [NUM_HARTS*DATA_WIDTH-1:0] exit_code_o,
    output logic                            all_done_o,
    output logic                            all_pass_o,
    output logic                            timeout_o,
    output logic [15:0]                     drop_cnt_o
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int B   = $clog2(NB);
    localparam int LW  = (B > 0) ? B : 1;
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int EW  = HW + 8;

    typedef enum logic {RUNNING = 1'b0, EXITED = 1'b1} exit_state_e;

    // Shifting instead of slicing keeps DATA_WIDTH=8 (no lane bits) legal.
    function automatic logic word_hit(input logic [ADDR_WIDTH-1:0] a,
                                      input logic [ADDR_WIDTH-1:0] b);
        return (a >> B) == (b >> B);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] strb_merge(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [NB-1:0] s);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int j = 0; j < NB; j++)
            if (s[j]) r[j*8 +: 8] = d[j*8 +: 8];
        return r;
    endfunction

    // ---------------- write decode ----------------
    logic [LW-1:0]        lane     [NUM_HARTS];
    logic [7:0]           std_char [NUM_HARTS];
    logic [NUM_HARTS-1:0] std_cap, th_trig, exited_next;
    exit_state_e          exit_state_q [NUM_HARTS];

    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            lane[h]     = LW'(stdout_addr_i[h*ADDR_WIDTH +: ADDR_WIDTH] & ADDR_WIDTH'(NB - 1));
            std_char[h] = mem_wdata_i[h*DATA_WIDTH + 8*lane[h] +: 8];
            std_cap[h]  = mem_we_i[h]
                       && word_hit(mem_waddr_i[h*ADDR_WIDTH +: ADDR_WIDTH],
                                   stdout_addr_i[h*ADDR_WIDTH +: ADDR_WIDTH])
                       && mem_wstrb_i[h*NB + lane[h]];
            th_trig[h]  = mem_we_i[h] && (exit_state_q[h] == RUNNING)
                       && word_hit(mem_waddr_i[h*ADDR_WIDTH +: ADDR_WIDTH],
                                   tohost_addr_i[h*ADDR_WIDTH +: ADDR_WIDTH]);
            exited_o[h]    = (exit_state_q[h] == EXITED);
            exited_next[h] = exited_o[h] | th_trig[h];
        end
    end

    // ---------------- staging + round-robin arbiter ----------------
    logic [NUM_HARTS-1:0] stg_valid_q, granted;
    logic [7:0]           stg_data_q [NUM_HARTS];
    logic [HW-1:0]        rr_q, grant_idx, cand;
    logic                 grant_valid, push, pop, fifo_empty, fifo_full;
    logic [15:0]          drop_cnt_q;
    logic [16:0]          drop_sum;

    // First full staging register at or after rr_q (rr_q = hart after last grant).
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            cand = HW'((int'(rr_q) + k) % NUM_HARTS);
            if (!grant_valid && stg_valid_q[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign pop  = !fifo_empty && char_ready_i;
    assign push = grant_valid && (!fifo_full || pop);

    // Several harts can drop in the same cycle; the extra bit flags saturation.
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int h = 0; h < NUM_HARTS; h++) begin
            granted[h] = push && (grant_idx == HW'(h));
            if (std_cap[h] && stg_valid_q[h] && !granted[h])
                drop_sum = drop_sum + 17'd1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            stg_valid_q <= '0;
            rr_q        <= '0;
            drop_cnt_q  <= '0;
            for (int h = 0; h < NUM_HARTS; h++) stg_data_q[h] <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                // A granted register empties this edge, so it can take a new char.
                if (std_cap[h] && (!stg_valid_q[h] || granted[h])) begin
                    stg_valid_q[h] <= 1'b1;
                    stg_data_q[h]  <= std_char[h];
                end else if (granted[h]) begin
                    stg_valid_q[h] <= 1'b0;
                end
            end
            if (push)
                rr_q <= (grant_idx == HW'(NUM_HARTS - 1)) ? '0 : grant_idx + 1'b1;
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // ---------------- character FIFO (show-ahead) ----------------
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [FAW:0]  wr_q, rd_q;

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[FAW] != rd_q[FAW]) && (wr_q[FAW-1:0] == rd_q[FAW-1:0]);

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_q[FAW-1:0]] <= {grant_idx, stg_data_q[grant_idx]};
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Masked while empty so the outputs read 0 out of reset.
    assign char_valid_o = !fifo_empty;
    assign {char_hart_o, char_data_o} = fifo_empty ? '0 : fifo_mem[rd_q[FAW-1:0]];
    assign drop_cnt_o   = drop_cnt_q;

    // ---------------- exit FSMs, done/pass, timeout ----------------
    logic [NUM_HARTS*DATA_WIDTH-1:0] exit_code_q;
    logic                            all_done_q, timeout_q;
    logic [31:0]                     cnt_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int h = 0; h < NUM_HARTS; h++) exit_state_q[h] <= RUNNING;
            exit_code_q <= '0;
            all_done_q  <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                case (exit_state_q[h])
                    RUNNING: if (th_trig[h]) begin
                        exit_state_q[h] <= EXITED;
                        exit_code_q[h*DATA_WIDTH +: DATA_WIDTH] <=
                            strb_merge(mem_wdata_i[h*DATA_WIDTH +: DATA_WIDTH],
                                       mem_wstrb_i[h*NB +: NB]);
                    end
                    default: ;  // EXITED is terminal until reset
                endcase
            end
            all_done_q <= &exited_next;
            // Counter freezes once done or timed out; done on the same edge wins.
            if (!all_done_q && !timeout_q) begin
                cnt_q <= cnt_q + 32'd1;
                if ((TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1)) && !(&exited_next))
                    timeout_q <= 1'b1;
            end
        end
    end

    assign exit_code_o = exit_code_q;
    assign all_done_o  = all_done_q;
    assign all_pass_o  = all_done_q && (exit_code_q == '0);
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_host_io_monitor.sv
`timescale 1ns/1ps
module tb_host_io_monitor;
    localparam int NH = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int NB = 8;
    localparam int FD = 16;
    localparam int TO = 50;
    localparam int HW = 2;

    logic             clk_i = 1'b0;
    logic             arst_ni = 1'b0;
    logic [NH*AW-1:0] tohost_addr_i, stdout_addr_i, mem_waddr_i;
    logic [NH-1:0]    mem_we_i;
    logic [NH*DW-1:0] mem_wdata_i;
    logic [NH*NB-1:0] mem_wstrb_i;
    logic             char_valid_o, char_ready_i;
    logic [7:0]       char_data_o;
    logic [HW-1:0]    char_hart_o;
    logic [NH-1:0]    exited_o;
    logic [NH*DW-1:0] exit_code_o;
    logic             all_done_o, all_pass_o, timeout_o;
    logic [15:0]      drop_cnt_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [HW+7:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    host_io_monitor #(
        .NUM_HARTS(NH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .tohost_addr_i(tohost_addr_i), .stdout_addr_i(stdout_addr_i),
        .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i),
        .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
        .char_valid_o(char_valid_o), .char_ready_i(char_ready_i),
        .char_data_o(char_data_o), .char_hart_o(char_hart_o),
        .exited_o(exited_o), .exit_code_o(exit_code_o),
        .all_done_o(all_done_o), .all_pass_o(all_pass_o),
        .timeout_o(timeout_o), .drop_cnt_o(drop_cnt_o)
    );

    // Hart 3's stdout sits in byte lane 3; the others use lane 0.
    function automatic int lane_of(input int h);
        return (h == 3) ? 3 : 0;
    endfunction
    function automatic logic [63:0] std_addr(input int h);
        return 64'h8000_1000 + 64'(h) * 64'h100 + 64'(lane_of(h));
    endfunction
    function automatic logic [63:0] th_addr(input int h);
        return 64'h8000_0000 + 64'(h) * 64'h100;
    endfunction

    // ---------------- clock/reset and drivers ----------------
    // One cycle: scoreboard at the negedge (handshake that pops on the next
    // posedge), then advance to 1ns past the posedge where inputs change.
    task automatic step();
        logic [HW+7:0] got, e;
        @(negedge clk_i);
        if (arst_ni && char_valid_o && char_ready_i) begin
            got = {char_hart_o, char_data_o};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL stream_extra: got hart %0d char %02h, required no character",
                         char_hart_o, char_data_o);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL stream_char: got hart %0d char %02h, required hart %0d char %02h",
                             got[HW+7:8], got[7:0], e[HW+7:8], e[7:0]);
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_writes();
        mem_we_i    = '0;
        mem_waddr_i = '0;
        mem_wdata_i = '0;
        mem_wstrb_i = '0;
    endtask

    task automatic set_write(input int h, input logic [63:0] addr,
                             input logic [63:0] data, input logic [7:0] strb);
        mem_we_i[h]            = 1'b1;
        mem_waddr_i[h*AW +: AW] = addr & ~64'h7;
        mem_wdata_i[h*DW +: DW] = data;
        mem_wstrb_i[h*NB +: NB] = strb;
    endtask

    task automatic put_char(input int h, input logic [7:0] c, input bit expect_out);
        set_write(h, std_addr(h), 64'(c) << (8 * lane_of(h)), 8'(1 << lane_of(h)));
        if (expect_out) exp_q.push_back({2'(h), c});
    endtask

    // Reset released 1ns after a posedge; the next step() is edge 1.
    task automatic apply_reset();
        arst_ni = 1'b0;
        clear_writes();
        char_ready_i = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        arst_ni = 1'b1;
    endtask

    task automatic flush();
        char_ready_i = 1'b1;
        for (int i = 0; i < 100 && (exp_q.size() != 0 || char_valid_o); i++) step();
        n_cmp++;
        if (exp_q.size() != 0 || char_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush: %0d chars still expected, char_valid=%0b, required 0 and 0",
                     exp_q.size(), char_valid_o);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        arst_ni = 1'b0;
        clear_writes();
        char_ready_i = 1'b0;
        #12;
        n_cmp++;
        if ({char_valid_o, char_data_o, char_hart_o, exited_o, all_done_o, all_pass_o, timeout_o} !== '0) begin
            n_err++;
            $display("FAIL reset_flags: valid=%0b data=%02h hart=%0d exited=%h done=%0b pass=%0b to=%0b, required all 0",
                     char_valid_o, char_data_o, char_hart_o, exited_o, all_done_o, all_pass_o, timeout_o);
        end
        n_cmp++;
        if (exit_code_o !== '0 || drop_cnt_o !== 16'h0) begin
            n_err++;
            $display("FAIL reset_regs: exit_code=%h drop=%0d, required 0 and 0", exit_code_o, drop_cnt_o);
        end
    endtask

    task automatic test_hello();
        apply_reset();
        char_ready_i = 1'b1;
        set_write(0, 64'h8000_1000, 64'h0A4948, 8'h07);
        exp_q.push_back({2'd0, 8'h48});
        step();                       // edge t: staging filled
        n_cmp++;
        if (char_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL hello_lat_t: char_valid=%0b, required 0", char_valid_o);
        end
        clear_writes();
        put_char(0, 8'h49, 1);
        step();                       // edge t+1: pushed to FIFO
        n_cmp++;
        if (char_valid_o !== 1'b1 || char_data_o !== 8'h48 || char_hart_o !== 2'd0) begin
            n_err++;
            $display("FAIL hello_lat_t1: valid=%0b data=%02h hart=%0d, required 1 48 0",
                     char_valid_o, char_data_o, char_hart_o);
        end
        clear_writes();
        put_char(0, 8'h0A, 1);
        step();
        clear_writes();
        flush();
        n_cmp++;
        if (drop_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL hello_drop: drop_cnt=%0d, required 0", drop_cnt_o);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        char_ready_i = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int h = 0; h < NH; h++) put_char(h, 8'($urandom_range(32, 126)), 1);
            step();
            clear_writes();
            flush();
        end
        // stdout word hit without the lane strobe produces nothing
        set_write(2, std_addr(2), 64'h55, 8'hFE);
        step();
        clear_writes();
        repeat (3) step();
        n_cmp++;
        if (char_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rr_nostrb: char_valid=%0b, required 0", char_valid_o);
        end
        n_cmp++;
        if (drop_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL rr_drop: drop_cnt=%0d, required 0", drop_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        char_ready_i = 1'b0;
        for (int i = 0; i < FD + 3; i++) begin
            clear_writes();
            put_char(1, 8'(8'h41 + i), i < FD + 1);
            step();
        end
        clear_writes();
        step();
        n_cmp++;
        if (drop_cnt_o !== 16'd2) begin
            n_err++;
            $display("FAIL bp_drop: drop_cnt=%0d, required 2", drop_cnt_o);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (char_valid_o !== 1'b1 || {char_hart_o, char_data_o} !== exp_q[0]) begin
                n_err++;
                $display("FAIL bp_hold: valid=%0b hart=%0d data=%02h, required 1 hart %0d data %02h",
                         char_valid_o, char_hart_o, char_data_o, exp_q[0][HW+7:8], exp_q[0][7:0]);
            end
            step();
        end
        flush();
        n_cmp++;
        if (drop_cnt_o !== 16'd2) begin
            n_err++;
            $display("FAIL bp_drop_after: drop_cnt=%0d, required 2", drop_cnt_o);
        end
    endtask

    task automatic test_exit();
        apply_reset();
        set_write(2, th_addr(2), 64'hDEAD_BEEF_0000_0001, 8'h0F);
        n_cmp++;
        if (exited_o !== 4'b0000) begin
            n_err++;
            $display("FAIL exit_pre: exited=%b, required 0000", exited_o);
        end
        step();
        clear_writes();
        n_cmp++;
        if (exited_o !== 4'b0100 || exit_code_o[2*DW +: DW] !== 64'h1) begin
            n_err++;
            $display("FAIL exit_capture: exited=%b code2=%h, required 0100 0000000000000001",
                     exited_o, exit_code_o[2*DW +: DW]);
        end
        set_write(2, th_addr(2), 64'h0, 8'hFF);
        step();
        clear_writes();
        n_cmp++;
        if (exit_code_o[2*DW +: DW] !== 64'h1 || all_done_o !== 1'b0) begin
            n_err++;
            $display("FAIL exit_ignored: code2=%h done=%0b, required 0000000000000001 0",
                     exit_code_o[2*DW +: DW], all_done_o);
        end
        set_write(0, th_addr(0), 64'h0, 8'hFF);
        set_write(1, th_addr(1), 64'h0, 8'hFF);
        set_write(3, th_addr(3), 64'h0, 8'hFF);
        step();
        clear_writes();
        n_cmp++;
        if (exited_o !== 4'b1111 || all_done_o !== 1'b1 || all_pass_o !== 1'b0 || timeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL exit_all: exited=%b done=%0b pass=%0b to=%0b, required 1111 1 0 0",
                     exited_o, all_done_o, all_pass_o, timeout_o);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        char_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clear_writes();
            put_char(0, 8'(8'h30 + i), 0);    // discarded by the reset below
            step();
        end
        clear_writes();
        repeat (TO - 4) step();               // edge 49
        n_cmp++;
        if (timeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL to_before: timeout=%0b at edge %0d, required 0", timeout_o, TO - 1);
        end
        step();                               // edge 50
        n_cmp++;
        if (timeout_o !== 1'b1 || char_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL to_at: timeout=%0b valid=%0b at edge %0d, required 1 1", timeout_o, char_valid_o, TO);
        end
        #2;
        arst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({char_valid_o, char_data_o, timeout_o, all_done_o, drop_cnt_o} !== '0) begin
            n_err++;
            $display("FAIL rst_async: valid=%0b data=%02h to=%0b done=%0b drop=%0d, required all 0",
                     char_valid_o, char_data_o, timeout_o, all_done_o, drop_cnt_o);
        end
        @(posedge clk_i);
        #1;
        arst_ni = 1'b1;
        char_ready_i = 1'b1;
        repeat (5) step();
        n_cmp++;
        if (char_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_fifo_empty: char_valid=%0b, required 0", char_valid_o);
        end
    endtask

    task automatic test_done_vs_timeout();
        apply_reset();
        repeat (TO - 1) step();               // edge 49
        for (int h = 0; h < NH; h++) set_write(h, th_addr(h), 64'h0, 8'hFF);
        step();                               // edge 50: exits and timeout coincide
        clear_writes();
        n_cmp++;
        if (all_done_o !== 1'b1 || all_pass_o !== 1'b1 || timeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL race_edge: done=%0b pass=%0b to=%0b, required 1 1 0",
                     all_done_o, all_pass_o, timeout_o);
        end
        repeat (10) step();
        n_cmp++;
        if (timeout_o !== 1'b0 || all_done_o !== 1'b1) begin
            n_err++;
            $display("FAIL race_later: to=%0b done=%0b, required 0 1", timeout_o, all_done_o);
        end
    endtask

    initial begin
        for (int h = 0; h < NH; h++) begin
            stdout_addr_i[h*AW +: AW] = std_addr(h);
            tohost_addr_i[h*AW +: AW] = th_addr(h);
        end
        test_reset();
        test_hello();
        test_round_robin();
        test_back_to_back();
        test_exit();
        test_timeout();
        test_done_vs_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200us, required finish");
        $fatal(1);
    end

endmodule
